bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 36 +++
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request, slave-ready and grant/error signals shared by the two masters,
// the three slaves and the bus arbiter.
interface bus_arbiter_if;
    logic       m1_req;
    logic       m2_req;
    logic [1:0] m1_slave_sel;
    logic [1:0] m2_slave_sel;
    logic       s1_slave_ready;
    logic       s2_slave_ready;
    logic       s3_slave_ready;
    logic [1:0] bus_grant;
    logic [1:0] slave_sel;
    logic       m1_grant;
    logic       m2_grant;
    logic       m1_timeout;
    logic       m2_timeout;
    logic       m1_sel_err;
    logic       m2_sel_err;
    logic       busy;

    // Requester/slave side: drives requests and readies, observes grants.
    modport master (
        output m1_req, m2_req, m1_slave_sel, m2_slave_sel,
        output s1_slave_ready, s2_slave_ready, s3_slave_ready,
        input  bus_grant, slave_sel, m1_grant, m2_grant,
        input  m1_timeout, m2_timeout, m1_sel_err, m2_sel_err, busy
    );

    // Arbiter side.
    modport slave (
        input  m1_req, m2_req, m1_slave_sel, m2_slave_sel,
        input  s1_slave_ready, s2_slave_ready, s3_slave_ready,
        output bus_grant, slave_sel, m1_grant, m2_grant,
        output m1_timeout, m2_timeout, m1_sel_err, m2_sel_err, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with slave-ready timeout, illegal-select
// detection and per-master lockout. All outputs come straight from flops.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, GRANT_M1, GRANT_M2, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lock_q, lock_d;
    logic             last_q, last_d;        // 0 = M1, 1 = M2
    logic             en_q;                  // holds off arbitration on the first edge after reset
    logic [1:0]       bus_grant_q, bus_grant_d;
    logic [1:0]       slave_sel_q, slave_sel_d;
    logic [1:0]       timeout_q, timeout_d;
    logic [1:0]       sel_err_q, sel_err_d;

    logic [1:0] req;
    logic [1:0] elig;
    logic       ready;
    logic       win;
    logic [1:0] win_sel;
    logic       gidx;
    logic       arb;

    assign req  = {bus.m2_req, bus.m1_req};
    assign elig = req & ~lock_q;

    // Ready of the slave latched for the current grant.
    always_comb begin
        ready = 1'b0;
        case (slave_sel_q)
            2'd1:    ready = bus.s1_slave_ready;
            2'd2:    ready = bus.s2_slave_ready;
            2'd3:    ready = bus.s3_slave_ready;
            default: ready = 1'b0;
        endcase
    end

    // Next state, timeout counter, lockout and registered-output next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q & req;
        last_d      = last_q;
        slave_sel_d = slave_sel_q;
        timeout_d   = 2'b00;
        sel_err_d   = 2'b00;
        bus_grant_d = 2'd0;
        arb         = 1'b0;
        gidx        = (state_q == GRANT_M2);
        win         = (elig == 2'b10) || ((elig == 2'b11) && !last_q);
        win_sel     = win ? bus.m2_slave_sel : bus.m1_slave_sel;

        case (state_q)
            IDLE:    arb = 1'b1;
            RELEASE: begin
                state_d = IDLE;
                arb     = 1'b1;
            end
            GRANT_M1, GRANT_M2: begin
                if (!req[gidx]) begin
                    state_d = RELEASE;
                end else if (!ready && (cnt_q == CNT_LAST)) begin
                    state_d         = RELEASE;
                    timeout_d[gidx] = 1'b1;
                    lock_d[gidx]    = 1'b1;
                end else if (ready) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb && en_q && (elig != 2'b00)) begin
            if (win_sel == 2'd0) begin
                sel_err_d[win] = 1'b1;
                lock_d[win]    = 1'b1;
                state_d        = IDLE;
            end else begin
                state_d     = win ? GRANT_M2 : GRANT_M1;
                slave_sel_d = win_sel;
                cnt_d       = '0;
                last_d      = win;
            end
        end

        case (state_d)
            GRANT_M1: bus_grant_d = 2'd1;
            GRANT_M2: bus_grant_d = 2'd2;
            default: begin
                bus_grant_d = 2'd0;
                slave_sel_d = 2'd0;
            end
        endcase
    end

    // State and output registers; async reset clears everything mid-transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lock_q      <= 2'b00;
            last_q      <= 1'b1;
            en_q        <= 1'b0;
            bus_grant_q <= 2'd0;
            slave_sel_q <= 2'd0;
            timeout_q   <= 2'b00;
            sel_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            last_q      <= last_d;
            en_q        <= 1'b1;
            bus_grant_q <= bus_grant_d;
            slave_sel_q <= slave_sel_d;
            timeout_q   <= timeout_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.bus_grant  = bus_grant_q;
    assign bus.slave_sel  = slave_sel_q;
    assign bus.m1_grant   = (bus_grant_q == 2'd1);
    assign bus.m2_grant   = (bus_grant_q == 2'd2);
    assign bus.busy       = (bus_grant_q != 2'd0);
    assign bus.m1_timeout = timeout_q[0];
    assign bus.m2_timeout = timeout_q[1];
    assign bus.m1_sel_err = sel_err_q[0];
    assign bus.m2_sel_err = sel_err_q[1];
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT_CYCLES = 4).
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    // Grant-related outputs all follow from the expected bus_grant/slave_sel.
    task automatic chk_bus(input string tag, input logic [1:0] g, input logic [1:0] s);
        chk({tag, ".bus_grant"}, 8'(bus.bus_grant), 8'(g));
        chk({tag, ".slave_sel"}, 8'(bus.slave_sel), 8'(s));
        chk({tag, ".m1_grant"},  8'(bus.m1_grant),  8'(g == 2'd1));
        chk({tag, ".m2_grant"},  8'(bus.m2_grant),  8'(g == 2'd2));
        chk({tag, ".busy"},      8'(bus.busy),      8'(g != 2'd0));
    endtask

    task automatic chk_err(input string tag, input logic t1, input logic t2,
                           input logic e1, input logic e2);
        chk({tag, ".m1_timeout"}, 8'(bus.m1_timeout), 8'(t1));
        chk({tag, ".m2_timeout"}, 8'(bus.m2_timeout), 8'(t2));
        chk({tag, ".m1_sel_err"}, 8'(bus.m1_sel_err), 8'(e1));
        chk({tag, ".m2_sel_err"}, 8'(bus.m2_sel_err), 8'(e2));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.m1_req = 1'b0;
        bus.m2_req = 1'b0;
        bus.m1_slave_sel = 2'd0;
        bus.m2_slave_sel = 2'd0;
        bus.s1_slave_ready = 1'b1;
        bus.s2_slave_ready = 1'b1;
        bus.s3_slave_ready = 1'b1;
        tick();
        tick();
        chk_bus("reset", 2'd0, 2'd0);
        chk_err("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single request, held through reset release: no grant on first edge.
        bus.m1_req = 1'b1;
        bus.m1_slave_sel = 2'd2;
        rst = 1'b1;
        tick();
        chk_bus("first_edge", 2'd0, 2'd0);
        tick();
        chk_bus("single_grant", 2'd1, 2'd2);
        bus.m1_slave_sel = 2'd3;
        tick();
        chk_bus("sel_ignored", 2'd1, 2'd2);
        bus.m1_req = 1'b0;
        tick();
        chk_bus("release", 2'd0, 2'd0);
        tick();
        chk_bus("idle", 2'd0, 2'd0);

        // Round-robin: last grant was M1, so M2 goes first here.
        bus.m1_req = 1'b1;
        bus.m1_slave_sel = 2'd1;
        bus.m2_req = 1'b1;
        bus.m2_slave_sel = 2'd3;
        tick();
        chk_bus("rr_m2", 2'd2, 2'd3);
        bus.m2_req = 1'b0;
        tick();
        chk_bus("rr_gap1", 2'd0, 2'd0);
        bus.m2_req = 1'b1;
        tick();
        chk_bus("rr_m1", 2'd1, 2'd1);
        bus.m1_req = 1'b0;
        tick();
        chk_bus("rr_gap2", 2'd0, 2'd0);
        bus.m1_req = 1'b1;
        tick();
        chk_bus("rr_m2b", 2'd2, 2'd3);
        bus.m1_req = 1'b0;
        bus.m2_req = 1'b0;
        tick();
        tick();
        chk_bus("rr_idle", 2'd0, 2'd0);

        // Timeout: M2 to slave 3 with ready low, four granted cycles.
        bus.s3_slave_ready = 1'b0;
        bus.m2_req = 1'b1;
        bus.m2_slave_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_bus($sformatf("to_grant%0d", i), 2'd2, 2'd3);
            chk_err("to_wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_bus("to_release", 2'd0, 2'd0);
        chk_err("to_pulse", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_bus("to_locked", 2'd0, 2'd0);
        chk_err("to_pulse_end", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.m2_req = 1'b0;
        tick();
        chk_bus("to_unlock", 2'd0, 2'd0);
        bus.s3_slave_ready = 1'b1;
        bus.m2_req = 1'b1;
        tick();
        chk_bus("to_regrant", 2'd2, 2'd3);
        for (int i = 0; i < 6; i++) tick();
        chk_bus("ready_keeps", 2'd2, 2'd3);
        chk_err("ready_no_to", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.m2_req = 1'b0;
        tick();
        tick();

        // Illegal select, M1 alone.
        bus.m1_req = 1'b1;
        bus.m1_slave_sel = 2'd0;
        tick();
        chk_bus("selerr", 2'd0, 2'd0);
        chk_err("selerr_pulse", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_err("selerr_once", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_bus("selerr_held", 2'd0, 2'd0);
        bus.m1_req = 1'b0;
        tick();

        // Illegal select on the round-robin winner: loser waits one cycle.
        bus.m1_req = 1'b1;
        bus.m2_req = 1'b1;
        bus.m2_slave_sel = 2'd1;
        tick();
        chk_bus("selerr_loser", 2'd0, 2'd0);
        chk_err("selerr_both", 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_bus("loser_next", 2'd2, 2'd1);
        bus.m1_req = 1'b0;
        bus.m2_req = 1'b0;
        tick();
        tick();

        // Reset mid-grant clears outputs asynchronously; M1 wins afterwards.
        bus.m1_req = 1'b1;
        bus.m1_slave_sel = 2'd1;
        tick();
        chk_bus("pre_rst", 2'd1, 2'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_bus("async_rst", 2'd0, 2'd0);
        bus.m2_req = 1'b1;
        bus.m2_slave_sel = 2'd2;
        tick();
        rst = 1'b1;
        tick();
        chk_bus("post_rst_edge1", 2'd0, 2'd0);
        tick();
        chk_bus("post_rst_m1", 2'd1, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
